lvds_stream_arbiter: RTL and testbench
======================================

LVDS_STREAM_ARBITER -- requirements
Module: lvds_stream_arbiter

Interface
REQ-001 Parameter FRAME_IRQ, default 1000: number of completed frames that raises an interrupt.
REQ-002 Parameter IDLE_TIMEOUT, default 10000: number of idle clk cycles that raises a flush interrupt.
REQ-003 Parameter DW, default 8: stream data width in bits.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 s0_tvalid/s0_tlast  input  1 each; s0_tdata  input  DW; s0_tready  output  1: AXI-Stream slave, receiver channel 0.
REQ-007 s1_tvalid/s1_tlast  input  1 each; s1_tdata  input  DW; s1_tready  output  1: AXI-Stream slave, receiver channel 1.
REQ-008 m_axis_tvalid/m_axis_tlast  output  1 each; m_axis_tdata  output  DW; m_axis_tready  input  1: merged master toward the DMA FIFO.
REQ-009 wr_rst_busy  input  1: downstream FIFO is in reset; no new grant may be issued.
REQ-010 user_irq_ack  input  1: host acknowledge of usr_irq_req.
REQ-011 usr_irq_req  output  1: interrupt request, level, held until acknowledged.
REQ-012 grant  output  2: one-hot owner; 00 when idle, 01 for ch0, 10 for ch1.
REQ-013 frame_total  output  32: count of frames forwarded since reset, wraps 0xFFFFFFFF->0.

Function
REQ-014 FSM states: IDLE, XFER; state and grant are registered.
REQ-015 IDLE -> XFER when wr_rst_busy=0 and at least one sN_tvalid=1; grant is loaded on the same edge.
REQ-016 If both channels are valid in IDLE, grant goes to the channel not served last (round-robin); after reset ch0 has priority.
REQ-017 XFER -> IDLE on the cycle where the granted channel beat is accepted with tlast=1; last-served toggles to that channel.
REQ-018 Arbitration is frame-granular: grant never changes between the first beat and the tlast beat of a frame.
REQ-019 In XFER the datapath is combinational: m_axis_tvalid/tdata/tlast = granted sN signals; the granted sN_tready = m_axis_tready; zero-cycle latency.
REQ-020 In IDLE, and for the non-granted channel, tready=0 and m_axis_tvalid=0; m_axis_tdata and m_axis_tlast drive 0 when m_axis_tvalid=0.
REQ-021 A beat is transferred only when valid and ready are both 1 on the same edge.
REQ-022 wr_rst_busy rising in XFER does not abort the frame; it only blocks the next IDLE->XFER.
REQ-023 Irq frame counter (width clog2(FRAME_IRQ+1)) increments per accepted tlast beat; at FRAME_IRQ it clears and sets usr_irq_req.
REQ-024 Idle timer counts cycles in IDLE with both sN_tvalid=0 and irq frame counter nonzero; it clears on any grant.
REQ-025 When the idle timer reaches IDLE_TIMEOUT: set usr_irq_req, clear timer and irq frame counter.
REQ-026 usr_irq_req clears on user_irq_ack=1; a set and an ack in the same cycle leave usr_irq_req=1.
REQ-027 A set while usr_irq_req is already 1 is absorbed (no queuing); counters still clear.
REQ-028 frame_total increments on every accepted tlast beat, independent of interrupt logic.

Reset
REQ-029 rst_n=0 asynchronously forces: state IDLE, grant=00, last-served=ch1, counters 0, frame_total=0, usr_irq_req=0, all tready/m_axis outputs 0.
REQ-030 Reset mid-frame drops the frame; after release the next grant starts at a fresh frame with ch0 priority.

Structure
REQ-031 State encoding and grant one-hot constants reside in a shared package lvds_pkg, together with FRAME_IRQ/IDLE_TIMEOUT defaults.
REQ-032 One sub-module lvds_irq_ctrl holds the irq frame counter, idle timer and usr_irq_req latch; the arbiter FSM and mux stay in the top.

Verification
REQ-033 ch0 only sends 4-beat frame, m_axis_tready=1 -> grant=01 one cycle after tvalid, 4 beats out unchanged, tlast on beat 4, frame_total=1, grant=00 after.
REQ-034 Both channels valid from reset with 3 frames each -> output order ch0,ch1,ch0,ch1,ch0,ch1; no beat interleaving inside a frame.
REQ-035 m_axis_tready toggled 1,0,1,0 mid-frame -> granted sN_tready mirrors it, no beat lost or duplicated, other channel tready=0 throughout.
REQ-036 FRAME_IRQ=3: forward 3 frames -> usr_irq_req=1 the cycle after 3rd tlast; user_irq_ack pulse -> 0 next edge; ack coincident with 6th tlast -> stays 1.
REQ-037 IDLE_TIMEOUT=20: 1 frame then idle -> usr_irq_req=1 after 20 idle cycles; with zero prior frames no irq after 100 idle cycles.
REQ-038 wr_rst_busy=1 with ch1 valid -> grant stays 00; deassert -> grant=10 next edge; rst_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/lvds_stream_arbiter_pkg.sv
// Shared definitions for the LVDS stream arbiter.
//   state_t          : arbiter FSM states (IDLE, XFER)
//   GRANT_*          : one-hot grant codes driven on the grant output
//   *_DEFAULT        : default interrupt thresholds used by the top and irq block
package lvds_pkg;

  localparam int FRAME_IRQ_DEFAULT    = 1000;
  localparam int IDLE_TIMEOUT_DEFAULT = 10000;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CH0  = 2'b01;
  localparam logic [1:0] GRANT_CH1  = 2'b10;

endpackage

// File: rtl/lvds_stream_arbiter_if.sv
// AXI-Stream style link used for both receiver channels and the merged output.
//   tvalid/tdata/tlast : driven by the source (master modport)
//   tready             : driven by the sink (slave modport)
interface lvds_stream_arbiter_if #(
  parameter int DW = 8
);

  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/lvds_stream_arbiter_irq_ctrl.sv
// Interrupt generation for the stream arbiter.
//   frame_done   : a tlast beat was accepted this cycle
//   idle_quiet   : arbiter idle and neither channel presenting data
//   grant_evt    : arbiter issues a new grant this cycle
//   user_irq_ack : host acknowledge
//   usr_irq_req  : level interrupt, held until acknowledged
// Raises the interrupt every FRAME_IRQ frames, or when frames are pending and
// the link has been quiet for IDLE_TIMEOUT cycles (flush).
module lvds_irq_ctrl
  import lvds_pkg::*;
#(
  parameter int FRAME_IRQ    = FRAME_IRQ_DEFAULT,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_done,
  input  logic idle_quiet,
  input  logic grant_evt,
  input  logic user_irq_ack,
  output logic usr_irq_req
);

  localparam int FCW = $clog2(FRAME_IRQ + 1);
  localparam int TCW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [FCW-1:0] FRAME_LAST   = FCW'(FRAME_IRQ);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(IDLE_TIMEOUT);

  logic [FCW-1:0] frame_cnt;
  logic [TCW-1:0] idle_cnt;
  logic           frames_pending;
  logic           frame_hit;
  logic           idle_hit;
  logic           irq_set;

  assign frames_pending = (frame_cnt != '0);
  assign frame_hit      = frame_done && ((frame_cnt + FCW'(1)) == FRAME_LAST);
  assign idle_hit       = idle_quiet && frames_pending && ((idle_cnt + TCW'(1)) == TIMEOUT_LAST);
  assign irq_set        = frame_hit || idle_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      idle_cnt    <= '0;
      usr_irq_req <= 1'b0;
    end else begin
      if (irq_set) begin
        frame_cnt <= '0;
      end else if (frame_done) begin
        frame_cnt <= frame_cnt + FCW'(1);
      end

      if (grant_evt || idle_hit) begin
        idle_cnt <= '0;
      end else if (idle_quiet && frames_pending) begin
        idle_cnt <= idle_cnt + TCW'(1);
      end

      // A set wins over a coincident ack so the new event is never lost;
      // a set while already pending simply merges into the held level.
      if (irq_set) begin
        usr_irq_req <= 1'b1;
      end else if (user_irq_ack) begin
        usr_irq_req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lvds_stream_arbiter.sv
// Frame-granular round-robin arbiter merging two LVDS receiver streams into
// one AXI-Stream toward a DMA FIFO.
//   clk, rst_n    : clock, asynchronous active-low reset
//   s0, s1        : receiver channel inputs (slave modport)
//   m_axis        : merged output (master modport), zero-latency mux
//   wr_rst_busy   : downstream FIFO in reset, blocks new grants only
//   user_irq_ack  : host interrupt acknowledge
//   usr_irq_req   : interrupt request level
//   grant         : one-hot current owner (00 idle, 01 ch0, 10 ch1)
//   frame_total   : frames forwarded since reset (wrapping)
module lvds_stream_arbiter
  import lvds_pkg::*;
#(
  parameter int FRAME_IRQ    = FRAME_IRQ_DEFAULT,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT,
  parameter int DW           = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lvds_stream_arbiter_if.slave  s0,
  lvds_stream_arbiter_if.slave  s1,
  lvds_stream_arbiter_if.master m_axis,
  input  logic                  wr_rst_busy,
  input  logic                  user_irq_ack,
  output logic                  usr_irq_req,
  output logic [1:0]            grant,
  output logic [31:0]           frame_total
);

  state_t        state, state_n;
  logic [1:0]    grant_n;
  logic          last_ch1, last_ch1_n;   // 1: ch1 was served most recently
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic          out_valid;
  logic          frame_done;
  logic          grant_evt;
  logic          idle_quiet;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    case (grant)
      GRANT_CH0: begin
        sel_valid = s0.tvalid;
        sel_last  = s0.tlast;
        sel_data  = s0.tdata;
      end
      GRANT_CH1: begin
        sel_valid = s1.tvalid;
        sel_last  = s1.tlast;
        sel_data  = s1.tdata;
      end
      default: ;
    endcase
  end

  // Output side is purely combinational from the registered grant; data and
  // tlast are forced to zero whenever nothing valid is presented.
  assign out_valid     = (state == XFER) && sel_valid;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? sel_data : '0;
  assign m_axis.tlast  = out_valid && sel_last;
  assign s0.tready     = (state == XFER) && (grant == GRANT_CH0) && m_axis.tready;
  assign s1.tready     = (state == XFER) && (grant == GRANT_CH1) && m_axis.tready;

  assign frame_done = out_valid && m_axis.tready && sel_last;
  assign idle_quiet = (state == IDLE) && !s0.tvalid && !s1.tvalid;

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    last_ch1_n = last_ch1;
    grant_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (!wr_rst_busy && (s0.tvalid || s1.tvalid)) begin
          state_n   = XFER;
          grant_evt = 1'b1;
          if (s0.tvalid && s1.tvalid) begin
            grant_n = last_ch1 ? GRANT_CH0 : GRANT_CH1;
          end else begin
            grant_n = s0.tvalid ? GRANT_CH0 : GRANT_CH1;
          end
        end
      end
      XFER: begin
        // Grant is held until the owner's tlast beat is taken, so frames
        // from the two channels never interleave.
        if (frame_done) begin
          state_n    = IDLE;
          grant_n    = GRANT_NONE;
          last_ch1_n = (grant == GRANT_CH1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= GRANT_NONE;
      last_ch1    <= 1'b1;
      frame_total <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      last_ch1 <= last_ch1_n;
      if (frame_done) begin
        frame_total <= frame_total + 32'd1;
      end
    end
  end

  lvds_irq_ctrl #(
    .FRAME_IRQ    (FRAME_IRQ),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_irq_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_done   (frame_done),
    .idle_quiet   (idle_quiet),
    .grant_evt    (grant_evt),
    .user_irq_ack (user_irq_ack),
    .usr_irq_req  (usr_irq_req)
  );

endmodule

// File: tb/tb_lvds_stream_arbiter.sv
`timescale 1ns/1ps
module tb_lvds_stream_arbiter;

  localparam int DW         = 8;
  localparam int BEAT_LIMIT = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_rst_busy = 1'b0;
  logic        user_irq_ack = 1'b0;
  logic        usr_irq_req;
  logic [1:0]  grant;
  logic [31:0] frame_total;

  lvds_stream_arbiter_if #(.DW(DW)) s0_if ();
  lvds_stream_arbiter_if #(.DW(DW)) s1_if ();
  lvds_stream_arbiter_if #(.DW(DW)) m_if ();

  lvds_stream_arbiter #(
    .FRAME_IRQ    (3),
    .IDLE_TIMEOUT (20),
    .DW           (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s0           (s0_if),
    .s1           (s1_if),
    .m_axis       (m_if),
    .wr_rst_busy  (wr_rst_busy),
    .user_irq_ack (user_irq_ack),
    .usr_irq_req  (usr_irq_req),
    .grant        (grant),
    .frame_total  (frame_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard: per-channel expected beats {tlast, tdata}, pushed by the
  // stimulus, and optional expected frame ownership order.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic [1:0]  exp_order[$];
  int          exp_total = 0;
  bit          in_frame = 0;
  logic [1:0]  frame_grant = 2'b00;
  bit          mon_en = 1'b1;
  bit          rand_done = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int ch, input logic v, input logic [DW-1:0] d, input logic l);
    if (ch == 0) begin
      s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l;
    end else begin
      s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l;
    end
  endtask

  function automatic logic chan_ready(input int ch);
    return (ch == 0) ? s0_if.tready : s1_if.tready;
  endfunction

  // Drives one frame on a channel; every beat is pushed to that channel's
  // expected queue as it is presented.
  task automatic drive_frame(input int ch, input int len, input int max_gap, input bit ack_last);
    logic [DW-1:0] d;
    logic          l;
    int            wait_cnt;
    for (int b = 0; b < len; b++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        if (g > 0) begin
          set_beat(ch, 1'b0, '0, 1'b0);
          repeat (g) sync();
        end
      end
      d = DW'($urandom);
      l = (b == len - 1);
      if (ch == 0) q0.push_back({l, d});
      else         q1.push_back({l, d});
      set_beat(ch, 1'b1, d, l);
      if (ack_last && l) user_irq_ack = 1'b1;
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        if (chan_ready(ch)) break;
        wait_cnt++;
        if (wait_cnt > BEAT_LIMIT) break;
      end
      if (wait_cnt > BEAT_LIMIT) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout ch=%0d beat=%0d waited=%0d cycles", ch, b, wait_cnt);
        set_beat(ch, 1'b0, '0, 1'b0);
        return;
      end
      sync();
      if (ack_last && l) user_irq_ack = 1'b0;
    end
    set_beat(ch, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    repeat (2) sync();
    rst_n = 1'b1;
  endtask

  // Monitor: compares every accepted output beat against the scoreboard and
  // checks the handshake rules each cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_total = 0;
      in_frame  = 0;
    end else if (mon_en) begin
      check("frame_total", frame_total, exp_total);
      if (!m_if.tvalid) check("m_idle_zero", {m_if.tlast, m_if.tdata}, 0);
      case (grant)
        2'b00: check("idle_outputs", {s0_if.tready, s1_if.tready, m_if.tvalid}, 0);
        2'b01: begin
          check("ch1_tready_blocked", s1_if.tready, 0);
          check("ch0_tready_mirror", s0_if.tready, m_if.tready);
          check("ch0_tvalid_pass", m_if.tvalid, s0_if.tvalid);
        end
        2'b10: begin
          check("ch0_tready_blocked", s0_if.tready, 0);
          check("ch1_tready_mirror", s1_if.tready, m_if.tready);
          check("ch1_tvalid_pass", m_if.tvalid, s1_if.tvalid);
        end
        default: check("grant_onehot", grant, 2'b00);
      endcase
      if (m_if.tvalid && m_if.tready) begin
        logic [DW:0] exp_beat;
        bit          have;
        have = 1'b0;
        exp_beat = '0;
        if (in_frame) check("frame_grant_stable", grant, frame_grant);
        else begin
          in_frame = 1;
          frame_grant = grant;
        end
        if (grant == 2'b01 && q0.size() > 0) begin
          exp_beat = q0.pop_front(); have = 1'b1;
        end else if (grant == 2'b10 && q1.size() > 0) begin
          exp_beat = q1.pop_front(); have = 1'b1;
        end
        if (have) check("beat_data", {m_if.tlast, m_if.tdata}, exp_beat);
        else begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat grant=%b data=%0h last=%0b", grant, m_if.tdata, m_if.tlast);
        end
        if (m_if.tlast) begin
          in_frame = 0;
          exp_total++;
          if (exp_order.size() > 0) check("frame_order", grant, exp_order.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    set_beat(0, 1'b0, '0, 1'b0);
    set_beat(1, 1'b0, '0, 1'b0);
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_irq", usr_irq_req, 0);
    check("rst_frame_total", frame_total, 0);
    check("rst_outputs", {s0_if.tready, s1_if.tready, m_if.tvalid, m_if.tlast}, 0);

    // Single 4-beat frame on ch0, then flush interrupt after 20 idle cycles
    sync();
    fork
      drive_frame(0, 4, 0, 0);
      begin
        @(negedge clk); check("grant_before_edge", grant, 2'b00);
        @(negedge clk); check("grant_latency", grant, 2'b01);
      end
    join
    @(negedge clk);
    check("grant_release", grant, 2'b00);
    check("single_frame_total", frame_total, 1);
    repeat (19) @(negedge clk);
    check("idle_irq_early", usr_irq_req, 0);
    @(negedge clk);
    check("idle_irq_fire", usr_irq_req, 1);
    sync(); user_irq_ack = 1'b1;
    sync(); user_irq_ack = 1'b0;
    @(negedge clk);
    check("idle_irq_ack", usr_irq_req, 0);
    repeat (100) @(negedge clk);
    check("no_idle_irq_without_frames", usr_irq_req, 0);

    // Both channels busy from reset: strict alternation starting at ch0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_order.push_back(2'b01);
      exp_order.push_back(2'b10);
    end
    fork
      for (int f = 0; f < 3; f++) drive_frame(0, 3, 0, 0);
      for (int f = 0; f < 3; f++) drive_frame(1, 2, 0, 0);
    join
    @(negedge clk);
    check("rr_order_drained", exp_order.size(), 0);

    // Backpressure toggling mid-frame
    sync();
    fork
      drive_frame(0, 6, 0, 0);
      begin
        for (int i = 0; i < 8; i++) begin
          m_if.tready = (i % 2 == 0);
          sync();
        end
        m_if.tready = 1'b1;
      end
    join

    // Frame-count interrupt with FRAME_IRQ=3, ack, and ack colliding with a set
    do_reset();
    drive_frame(0, 2, 0, 0);
    drive_frame(1, 3, 0, 0);
    @(negedge clk);
    check("frame_irq_early", usr_irq_req, 0);
    sync();
    drive_frame(0, 2, 0, 0);
    @(negedge clk);
    check("frame_irq_fire", usr_irq_req, 1);
    sync(); user_irq_ack = 1'b1;
    sync(); user_irq_ack = 1'b0;
    @(negedge clk);
    check("frame_irq_ack", usr_irq_req, 0);
    sync();
    drive_frame(1, 2, 0, 0);
    drive_frame(0, 3, 0, 0);
    drive_frame(1, 4, 0, 1);
    @(negedge clk);
    check("irq_set_beats_ack", usr_irq_req, 1);
    sync(); user_irq_ack = 1'b1;
    sync(); user_irq_ack = 1'b0;
    @(negedge clk);
    check("irq_final_ack", usr_irq_req, 0);

    // wr_rst_busy blocks new grants but not a frame in flight
    sync();
    wr_rst_busy = 1'b1;
    fork
      drive_frame(1, 4, 0, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("busy_blocks_grant", grant, 2'b00);
        end
        sync(); wr_rst_busy = 1'b0;
        @(negedge clk); check("busy_release_hold", grant, 2'b00);
        @(negedge clk); check("busy_release_grant", grant, 2'b10);
        sync(); wr_rst_busy = 1'b1;
      end
    join
    sync();
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'h3C; s0_if.tlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("busy_blocks_ch0", grant, 2'b00);
    end
    sync();
    set_beat(0, 1'b0, '0, 1'b0);
    wr_rst_busy = 1'b0;

    // Randomized traffic with random backpressure
    sync();
    fork
      begin
        fork
          for (int f = 0; f < 12; f++) drive_frame(0, $urandom_range(6, 1), 2, 0);
          for (int f = 0; f < 12; f++) drive_frame(1, $urandom_range(6, 1), 2, 0);
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        m_if.tready = ($urandom_range(3, 0) != 0);
        sync();
      end
    join
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("queues_drained", q0.size() + q1.size(), 0);

    // Asynchronous reset in the middle of a frame
    mon_en = 1'b0;
    sync();
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'hA5; s0_if.tlast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_grant", grant, 2'b01);
    check("pre_reset_tready", s0_if.tready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 2'b00);
    check("async_rst_m", {m_if.tvalid, m_if.tlast, m_if.tdata}, 0);
    check("async_rst_tready", {s0_if.tready, s1_if.tready}, 0);
    check("async_rst_total", frame_total, 0);
    check("async_rst_irq", usr_irq_req, 0);
    set_beat(0, 1'b0, '0, 1'b0);
    sync();
    rst_n = 1'b1;
    sync();
    s0_if.tvalid = 1'b1; s1_if.tvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_ch0_priority", grant, 2'b01);
    set_beat(0, 1'b0, '0, 1'b0);
    set_beat(1, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
